// File: rtl/pe_array_sequencer_if.sv
// Command, status and control bundle between the host-side control block,
// the PE array and the pass sequencer.
//   master : host/array side (drives command, abort/err_clr and array status)
//   slave  : sequencer side (drives array controls and host status)
interface pe_array_sequencer_if #(
  parameter int NUM_ROW = 7
);
  // Host command and control
  logic               cmd_valid;
  logic               cmd_ready;
  logic [7:0]         cmd_kernel_size;
  logic [15:0]        cmd_run_len;
  logic               cmd_psum_en;
  logic               cmd_skip_fltr;
  logic               abort;
  logic               err_clr;
  // Array status
  logic               ram_rst_busy;
  logic               tag_busy;
  logic               kernel_busy;
  logic               ram_load_busy;
  logic               full;
  // Array controls
  logic               load_ifmap;
  logic               load_fltr;
  logic               load_psum;
  logic               flush_tag;
  logic               flush_kernel;
  logic [7:0]         kernel_size;
  logic [NUM_ROW-1:0] start;
  // Host status
  logic               busy;
  logic               done;
  logic               err;
  logic [2:0]         err_code;
  logic [3:0]         state;

  modport master (
    output cmd_valid, cmd_kernel_size, cmd_run_len, cmd_psum_en, cmd_skip_fltr,
           abort, err_clr, ram_rst_busy, tag_busy, kernel_busy, ram_load_busy, full,
    input  cmd_ready, load_ifmap, load_fltr, load_psum, flush_tag, flush_kernel,
           kernel_size, start, busy, done, err, err_code, state
  );

  modport slave (
    input  cmd_valid, cmd_kernel_size, cmd_run_len, cmd_psum_en, cmd_skip_fltr,
           abort, err_clr, ram_rst_busy, tag_busy, kernel_busy, ram_load_busy, full,
    output cmd_ready, load_ifmap, load_fltr, load_psum, flush_tag, flush_kernel,
           kernel_size, start, busy, done, err, err_code, state
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// Sequences one convolution pass on the PE array: RAM reset wait, y-tag flush,
// kernel flush, filter/ifmap/psum loads, row start, drain, done.
// Ports:
//   clk  - controller clock (array clock domain)
//   rstn - asynchronous active-low reset
//   bus  - slave side of pe_array_sequencer_if (command, status, controls)
// All outputs are registered; phase commands are one-cycle pulses on entry.
module pe_array_sequencer #(
  parameter int NUM_ROW      = 7,
  parameter int NUM_COL      = 7,
  parameter int TIMEOUT      = 4096,
  parameter int DRAIN_CYCLES = NUM_ROW + NUM_COL
) (
  input logic                 clk,
  input logic                 rstn,
  pe_array_sequencer_if.slave bus
);
  localparam int CW     = $clog2(TIMEOUT + DRAIN_CYCLES + 1);
  // Pulse cycle plus two settle cycles before busy is trusted.
  localparam int SETTLE = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0, S_RSTW = 4'd1, S_TAG = 4'd2, S_KERN = 4'd3,
    S_LDF   = 4'd4, S_LDI  = 4'd5, S_LDP = 4'd6, S_RUN  = 4'd7,
    S_DRAIN = 4'd8, S_DONE = 4'd9, S_ERR = 4'd10
  } state_e;

  state_e             state_q, state_d, phase_nxt_s;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        run_cnt_q, run_cnt_d, run_len_q, run_len_d;
  logic [7:0]         ksize_q, ksize_d;
  logic               psum_q, psum_d, skip_q, skip_d;
  logic               err_q, err_d;
  logic [2:0]         code_q, code_d;
  logic               wait_busy_s, use_settle_s, phase_ok_s;
  logic               new_err_s, accept_s;
  logic [2:0]         new_code_s;
  logic [NUM_ROW-1:0] mask_s;
  logic               flush_tag_q, flush_tag_d, flush_kernel_q, flush_kernel_d;
  logic               load_fltr_q, load_fltr_d, load_ifmap_q, load_ifmap_d;
  logic               load_psum_q, load_psum_d;
  logic [NUM_ROW-1:0] start_q, start_d;
  logic               done_q, done_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;

  // Next-state selection, error detection and command acceptance.
  always_comb begin
    state_d      = state_q;
    phase_nxt_s  = S_IDLE;
    wait_busy_s  = 1'b0;
    use_settle_s = 1'b1;
    phase_ok_s   = 1'b0;
    new_err_s    = 1'b0;
    new_code_s   = 3'd0;
    accept_s     = 1'b0;
    // Which busy gates each wait phase and where it leads.
    case (state_q)
      S_RSTW:  begin wait_busy_s = bus.ram_rst_busy;  use_settle_s = 1'b0; phase_nxt_s = S_TAG; end
      S_TAG:   begin wait_busy_s = bus.tag_busy;      phase_nxt_s = S_KERN; end
      S_KERN:  begin wait_busy_s = bus.kernel_busy;   phase_nxt_s = skip_q ? S_LDI : S_LDF; end
      S_LDF:   begin wait_busy_s = bus.ram_load_busy; phase_nxt_s = S_LDI; end
      S_LDI:   begin wait_busy_s = bus.ram_load_busy; phase_nxt_s = psum_q ? S_LDP : S_RUN; end
      S_LDP:   begin wait_busy_s = bus.ram_load_busy; phase_nxt_s = S_RUN; end
      default: begin wait_busy_s = 1'b0;              phase_nxt_s = S_IDLE; end
    endcase
    phase_ok_s = !wait_busy_s && (!use_settle_s || (cnt_q >= CW'(SETTLE)));

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && !bus.abort) begin
          if ((bus.cmd_kernel_size == 8'd0) || (bus.cmd_kernel_size > 8'(NUM_ROW))) begin
            new_err_s  = 1'b1;
            new_code_s = 3'd1;
          end else begin
            accept_s = 1'b1;
            state_d  = S_RSTW;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RSTW, S_TAG, S_KERN, S_LDF, S_LDI, S_LDP: begin
        if (phase_ok_s) begin
          // A zero-length run has nothing to start; go straight to drain.
          if ((phase_nxt_s == S_RUN) && (run_len_q == 16'd0)) state_d = S_DRAIN;
          else                                                 state_d = phase_nxt_s;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = S_ERR;
          new_err_s  = 1'b1;
          new_code_s = 3'd2;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // Leave once the cycle currently driving start is the last counted one.
        if ((|start_q) && ((run_cnt_q + 16'd1) == run_len_q)) state_d = S_DRAIN;
        else                                                   state_d = S_RUN;
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = S_DONE;
        else                                state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR: begin
        if (bus.err_clr) state_d = S_IDLE;
        else             state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      new_err_s  = 1'b1;
      new_code_s = 3'd3;
      accept_s   = 1'b0;
    end else begin
      new_err_s = new_err_s;
    end
  end

  // Phase/run counters, captured command fields and sticky error.
  always_comb begin
    cnt_d     = cnt_q;
    run_cnt_d = run_cnt_q;
    if (state_d != state_q) begin
      cnt_d = {CW{1'b0}};
    end else if ((state_q == S_IDLE) || (state_q == S_ERR) || (state_q == S_RUN) || (state_q == S_DONE)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (accept_s)                          run_cnt_d = 16'd0;
    else if ((state_q == S_RUN) && |start_q) run_cnt_d = run_cnt_q + 16'd1;
    else                                   run_cnt_d = run_cnt_q;

    ksize_d   = accept_s ? bus.cmd_kernel_size : ksize_q;
    run_len_d = accept_s ? bus.cmd_run_len     : run_len_q;
    psum_d    = accept_s ? bus.cmd_psum_en     : psum_q;
    skip_d    = accept_s ? bus.cmd_skip_fltr   : skip_q;

    // A fresh error takes precedence over a clear in the same cycle.
    if (new_err_s) begin
      err_d  = 1'b1;
      code_d = new_code_s;
    end else if (bus.err_clr) begin
      err_d  = 1'b0;
      code_d = 3'd0;
    end else begin
      err_d  = err_q;
      code_d = code_q;
    end
  end

  // Next values of the registered array controls and host status.
  always_comb begin
    for (int i = 0; i < NUM_ROW; i++) begin
      mask_s[i] = (ksize_q > 8'(i));
    end
    flush_tag_d    = (state_d == S_TAG)  && (state_q != S_TAG);
    flush_kernel_d = (state_d == S_KERN) && (state_q != S_KERN);
    load_fltr_d    = (state_d == S_LDF)  && (state_q != S_LDF);
    load_ifmap_d   = (state_d == S_LDI)  && (state_q != S_LDI);
    load_psum_d    = (state_d == S_LDP)  && (state_q != S_LDP);
    // Array back-pressure blanks the row starts without consuming run length.
    if ((state_d == S_RUN) && !bus.full) start_d = mask_s;
    else                                 start_d = {NUM_ROW{1'b0}};
    done_d      = (state_d == S_DONE);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, counters and captured command fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      run_cnt_q <= 16'd0;
      run_len_q <= 16'd0;
      ksize_q   <= 8'd0;
      psum_q    <= 1'b0;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_cnt_q <= run_cnt_d;
      run_len_q <= run_len_d;
      ksize_q   <= ksize_d;
      psum_q    <= psum_d;
      skip_q    <= skip_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  // Registered array controls and host status.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_tag_q    <= 1'b0;
      flush_kernel_q <= 1'b0;
      load_fltr_q    <= 1'b0;
      load_ifmap_q   <= 1'b0;
      load_psum_q    <= 1'b0;
      start_q        <= {NUM_ROW{1'b0}};
      done_q         <= 1'b0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      flush_tag_q    <= flush_tag_d;
      flush_kernel_q <= flush_kernel_d;
      load_fltr_q    <= load_fltr_d;
      load_ifmap_q   <= load_ifmap_d;
      load_psum_q    <= load_psum_d;
      start_q        <= start_d;
      done_q         <= done_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.flush_tag    = flush_tag_q;
  assign bus.flush_kernel = flush_kernel_q;
  assign bus.load_fltr    = load_fltr_q;
  assign bus.load_ifmap   = load_ifmap_q;
  assign bus.load_psum    = load_psum_q;
  assign bus.start        = start_q;
  assign bus.done         = done_q;
  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.busy         = busy_q;
  assign bus.kernel_size  = ksize_q;
  assign bus.err          = err_q;
  assign bus.err_code     = code_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Randomised bench for pe_array_sequencer. An array model answers each
// command pulse with a busy window; expected pulse times, start pattern and
// done time are computed from the phase rules of the pass.
module tb_pe_array_sequencer;
  localparam int NR   = 7;
  localparam int NC   = 7;
  localparam int TMO  = 4096;
  localparam int DRN  = NR + NC;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pe_array_sequencer_if #(.NUM_ROW(NR)) bus();

  pe_array_sequencer #(.NUM_ROW(NR), .NUM_COL(NC), .TIMEOUT(TMO), .DRAIN_CYCLES(DRN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 1 tag, 2 kernel, 3 filter, 4 ifmap, 5 psum, 9 several at once, 0 none
  function automatic int pulse_code();
    int c;
    int k;
    c = 0;
    k = 0;
    if (bus.flush_tag)    begin c = 1; k++; end
    if (bus.flush_kernel) begin c = 2; k++; end
    if (bus.load_fltr)    begin c = 3; k++; end
    if (bus.load_ifmap)   begin c = 4; k++; end
    if (bus.load_psum)    begin c = 5; k++; end
    return (k > 1) ? 9 : c;
  endfunction

  function automatic logic [31:0] ctrl_vec();
    return {12'd0, bus.load_ifmap, bus.load_fltr, bus.load_psum, bus.flush_tag,
            bus.flush_kernel, bus.done, 7'(bus.start)};
  endfunction

  task automatic quiet_inputs();
    bus.cmd_valid = 1'b0; bus.abort = 1'b0; bus.err_clr = 1'b0;
    bus.ram_rst_busy = 1'b0; bus.tag_busy = 1'b0; bus.kernel_busy = 1'b0;
    bus.ram_load_busy = 1'b0; bus.full = 1'b0;
  endtask

  // mode: 0 full pass, 1 kernel busy stuck, 2 abort in ifmap load, 3 reset in run
  // full_mode: 0 never full, 1 four-cycle burst early in run, 2 random
  task automatic run_pass(input int k, input int rl, input bit psum, input bit skip,
                          input int mode, input int lat_fix, input int full_mode);
    int lat [1:5];
    int rr, p, run_entry, exp_n, pk, abort_cyc, done_cyc, n_done, limit, cnt, last, stray, exp_done;
    int rem_tag, rem_kern, rem_load;
    int exp_codes[$], exp_cyc[$], got_codes[$], got_cyc[$];
    logic [NR-1:0] obs_start [0:MAXC-1];
    bit fullh [0:MAXC-1];
    logic [NR-1:0] mask;
    logic [NR-1:0] e;
    bit finished;
    int budget;
    mask = '0;
    for (int i = 0; i < k && i < NR; i++) mask[i] = 1'b1;
    rr = $urandom_range(0, 4);
    for (int i = 1; i <= 5; i++) lat[i] = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 6);
    if (mode == 1) lat[2] = 1000000;
    exp_codes.push_back(1); exp_codes.push_back(2);
    if (!skip) exp_codes.push_back(3);
    exp_codes.push_back(4);
    if (psum) exp_codes.push_back(5);
    p = ((rr > 1) ? rr : 1) + 1;
    foreach (exp_codes[i]) begin
      exp_cyc.push_back(p);
      p += ((lat[exp_codes[i]] > 3) ? lat[exp_codes[i]] : 3) + 1;
    end
    run_entry = p;
    for (int n = 0; n < MAXC; n++) begin
      if (full_mode == 1)      fullh[n] = (n >= run_entry + 2) && (n < run_entry + 6);
      else if (full_mode == 2) fullh[n] = ($urandom_range(0, 3) == 0);
      else                     fullh[n] = 1'b0;
      obs_start[n] = '0;
    end
    bus.cmd_kernel_size = 8'(k); bus.cmd_run_len = 16'(rl);
    bus.cmd_psum_en = psum; bus.cmd_skip_fltr = skip;
    rem_tag = 0; rem_kern = 0; rem_load = 0; pk = -1; abort_cyc = -1;
    done_cyc = -1; n_done = 0; limit = 0; finished = 1'b0;
    budget = (mode == 1) ? 4800 : 2000;
    for (int n = 0; n < budget && !finished; n++) begin
      int c;
      c = pulse_code();
      obs_start[n] = bus.start;
      limit = n;
      if (c != 0) begin
        got_codes.push_back(c); got_cyc.push_back(n);
        case (c)
          1: rem_tag = lat[1];
          2: rem_kern = lat[2];
          3, 4, 5: rem_load = lat[c];
          default: ;
        endcase
      end
      if (bus.done) begin n_done++; if (done_cyc < 0) done_cyc = n; end
      if (n == 1 && mode != 3) check_eq("busy_in_pass", bus.busy, 1);
      if (mode == 0 && done_cyc >= 0 && n == done_cyc + 1) begin
        check_eq("ready_after_done", bus.cmd_ready, 1);
        check_eq("busy_after_done", bus.busy, 0);
        finished = 1'b1;
      end
      if (mode == 1 && got_cyc.size() >= 2) begin
        pk = got_cyc[1];
        if (n == pk + TMO - 1) check_eq("tmo_err_early", bus.err, 0);
        if (n == pk + TMO) begin
          check_eq("tmo_err", bus.err, 1);
          check_eq("tmo_code", bus.err_code, 2);
          check_eq("tmo_ctrl_zero", ctrl_vec(), 0);
          check_eq("tmo_not_ready", bus.cmd_ready, 0);
          finished = 1'b1;
        end
      end
      if (mode == 2) begin
        if (c == 4 && abort_cyc < 0) abort_cyc = n;
        if (abort_cyc >= 0 && n == abort_cyc + 1) begin
          check_eq("abort_err", bus.err, 1);
          check_eq("abort_code", bus.err_code, 3);
          check_eq("abort_ctrl_zero", ctrl_vec(), 0);
          check_eq("abort_idle_ready", bus.cmd_ready, 1);
          check_eq("abort_busy", bus.busy, 0);
          finished = 1'b1;
        end
      end
      if (mode == 3 && bus.start != '0) begin
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_start_zero", bus.start, 0);
        check_eq("rst_busy_zero", bus.busy, 0);
        check_eq("rst_ready", bus.cmd_ready, 1);
        finished = 1'b1;
      end
      if (!finished) begin
        bus.cmd_valid     = (n == 0);
        bus.ram_rst_busy  = (n < rr);
        bus.tag_busy      = (rem_tag > 0);
        bus.kernel_busy   = (rem_kern > 0);
        bus.ram_load_busy = (rem_load > 0);
        if (rem_tag > 0)  rem_tag--;
        if (rem_kern > 0) rem_kern--;
        if (rem_load > 0) rem_load--;
        bus.full  = fullh[n];
        bus.abort = (mode == 2) && (n == abort_cyc);
        @(negedge clk);
      end
    end
    quiet_inputs();
    check_eq("pass_end_reached", finished, 1);
    if (mode == 3) begin
      @(negedge clk); rstn = 1'b1; @(negedge clk);
    end
    exp_n = exp_codes.size();
    if (mode == 1) exp_n = 2;
    if (mode == 2) exp_n = skip ? 3 : 4;
    check_eq("pulse_count", got_codes.size(), exp_n);
    for (int i = 0; i < exp_n && i < got_codes.size(); i++) begin
      check_eq("pulse_kind", got_codes[i], exp_codes[i]);
      check_eq("pulse_cycle", got_cyc[i], exp_cyc[i]);
    end
    if (mode == 0) begin
      cnt = 0; last = -1;
      for (int n = run_entry; n <= limit && cnt < rl; n++) begin
        e = fullh[n-1] ? '0 : mask;
        check_eq("start_run", obs_start[n], e);
        if (e != '0) begin cnt++; last = n; end
      end
      check_eq("start_cycles", cnt, rl);
      stray = 0;
      for (int n = 0; n <= limit; n++)
        if ((n < run_entry || n > last) && obs_start[n] != '0) stray++;
      check_eq("start_outside_run", stray, 0);
      exp_done = (rl > 0) ? last + DRN + 1 : run_entry + DRN;
      check_eq("done_cycle", done_cyc, exp_done);
      check_eq("done_count", n_done, 1);
      check_eq("kernel_size_held", bus.kernel_size, k);
    end
  endtask

  task automatic bad_k(input int k, input bit clr, input int prev_k);
    int stray;
    bus.cmd_kernel_size = 8'(k); bus.cmd_run_len = 16'd4;
    bus.cmd_valid = 1'b1; bus.err_clr = clr;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.err_clr = 1'b0;
    check_eq("badk_err", bus.err, 1);
    check_eq("badk_code", bus.err_code, 1);
    check_eq("badk_idle", bus.cmd_ready, 1);
    check_eq("badk_ksize", bus.kernel_size, prev_k);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      if (ctrl_vec() != 0 || bus.busy) stray++;
      @(negedge clk);
    end
    check_eq("badk_no_pulse", stray, 0);
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check_eq("errclr_err", bus.err, 0);
    check_eq("errclr_code", bus.err_code, 0);
    check_eq("errclr_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    int k, rl;
    quiet_inputs();
    bus.cmd_kernel_size = 8'd0; bus.cmd_run_len = 16'd0;
    bus.cmd_psum_en = 1'b0; bus.cmd_skip_fltr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_ctrl", ctrl_vec(), 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_err", {bus.err, bus.err_code}, 0);
    check_eq("rst_state", bus.state, 0);
    check_eq("rst_ksize", bus.kernel_size, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_pass(3, 5, 1'b0, 1'b0, 0, 3, 0);
    run_pass(7, 6, 1'b1, 1'b1, 0, -1, 0);
    run_pass(5, 10, 1'b0, 1'b0, 0, -1, 1);
    run_pass(2, 0, 1'b1, 1'b0, 0, -1, 0);
    k = 2;
    for (int i = 0; i < 6; i++) begin
      k  = $urandom_range(1, NR);
      rl = $urandom_range(0, 20);
      run_pass(k, rl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1, 2);
    end

    bad_k(0, 1'b0, k);
    bad_k(8, 1'b1, k);
    clear_err();

    // abort in IDLE blocks the command
    bus.cmd_kernel_size = 8'd3; bus.cmd_run_len = 16'd2;
    bus.cmd_valid = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    quiet_inputs();
    check_eq("idle_abort_no_accept", bus.busy, 0);

    run_pass(4, 8, 1'b0, 1'b0, 1, -1, 0);
    clear_err();

    run_pass(3, 8, 1'b1, 1'b0, 2, -1, 0);
    run_pass(6, 4, 1'b0, 1'b0, 0, -1, 2);
    check_eq("err_sticky_after_pass", bus.err, 1);
    check_eq("code_sticky_after_pass", bus.err_code, 3);
    clear_err();

    run_pass(7, 50, 1'b0, 1'b0, 3, -1, 0);
    check_eq("post_rst_ksize", bus.kernel_size, 0);
    check_eq("post_rst_err", bus.err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Command-driven controller that sequences one convolution pass on the configurable PE array.
- Order: RAM reset wait, y-tag flush, kernel flush, filter/ifmap/psum loads, row start, drain.
- Drives the array's load/flush/start controls, handshakes on its busy/full status, and reports done/error to the host-side control (AXI-lite register block).

Parameters:
NUM_ROW, 7, PE array rows; width of start
NUM_COL, 7, PE array columns; used for drain length
TIMEOUT, 4096, max cycles waiting on any busy signal before error
DRAIN_CYCLES, NUM_ROW+NUM_COL, cycles held after last start before done

Ports:
clk  in  1  controller clock (same domain as array clk)
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_kernel_size  in  8  kernel size K for this pass
cmd_run_len  in  16  number of start-asserted cycles
cmd_psum_en  in  1  perform psum load phase
cmd_skip_fltr  in  1  reuse resident filter; skip filter load phase
abort  in  1  synchronous abort, any state
err_clr  in  1  clears sticky error
ram_rst_busy, tag_busy, kernel_busy, ram_load_busy, full  in  1 each  array status
load_ifmap, load_fltr, load_psum, flush_tag, flush_kernel  out  1 each  array controls
kernel_size  out  8  latched K to array
start  out  NUM_ROW  row start mask
busy  out  1  not IDLE
done  out  1  one-cycle pulse at pass completion
err  out  1  sticky error flag
err_code  out  3  0 none, 1 bad K, 2 timeout, 3 abort
state  out  4  current FSM state encoding (debug)

Behaviour:
- Reset:
  - All outputs 0 except cmd_ready=1.
  - state=IDLE; kernel_size=0; counters cleared.
  - Reset mid-pass drops every control the same cycle, because the reset is asynchronous.
- Control outputs are registered. Each phase command (flush_tag, flush_kernel, load_*) is a one-cycle pulse on phase entry.
- Busy-wait rule per phase:
  - Ignore busy for 2 cycles after the pulse (settle).
  - Then advance on the first cycle the phase's busy is low.
  - Timeout counter counts from the pulse. Reaching TIMEOUT goes to ERR with code 2.
- States:
  - IDLE: on cmd_valid, latch cmd fields.
    - K==0 or K>NUM_ROW: err=1, code 1, stay IDLE, no pulse.
    - Otherwise go to RSTW.
  - RSTW: wait ram_rst_busy low (busy-wait, no pulse, no settle) -> TAG.
  - TAG: flush_tag pulse; wait tag_busy -> KERN.
  - KERN: flush_kernel pulse; wait kernel_busy -> LDF, or LDI if skip_fltr.
  - LDF: load_fltr pulse; wait ram_load_busy -> LDI.
  - LDI: load_ifmap pulse; wait ram_load_busy -> LDP if psum_en, else RUN.
  - LDP: load_psum pulse; wait ram_load_busy -> RUN.
  - RUN:
    - start[i]=1 for i<K, else 0.
    - Run counter increments only on cycles with start asserted.
    - While full=1, start=0 and the counter holds; full is not subject to timeout.
    - Exit after cmd_run_len counted cycles. run_len=0 skips straight to DRAIN with no start.
  - DRAIN: start=0; count DRAIN_CYCLES -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: all controls 0. Return to IDLE on err_clr; err stays sticky until then.
- abort:
  - In any non-IDLE state: next cycle all controls 0, err=1, code 3, go to IDLE.
  - abort overrides cmd_valid in the same cycle.
- err_clr:
  - Clears err and err_code in any state.
  - A new error in the same cycle wins over err_clr.
- A command is accepted while err=1, provided no abort or error occurs in that cycle.
- kernel_size output is held from acceptance until the next accepted command.

Test Plan:
1. K=3, run_len=5, psum_en=0, busy signals drop 3 cycles after each pulse:
   - Pulses in order flush_tag, flush_kernel, load_fltr, load_ifmap.
   - start=7'b0000111 for exactly 5 cycles, then 14 drain cycles, then one done pulse; cmd_ready returns to 1.
2. K=7, psum_en=1, skip_fltr=1:
   - No load_fltr pulse; load_psum follows load_ifmap.
   - start=7'b1111111 for run_len cycles.
3. K=0, then K=8: each gives err=1, code 1, no control pulse, still IDLE. err_clr -> err=0.
4. kernel_busy held high: ERR at TIMEOUT=4096 cycles after the flush_kernel pulse, code 2, all controls 0.
5. RUN with run_len=10 and full high for 4 cycles mid-run:
   - start low during those 4 cycles; 10 asserted start cycles in total.
   - Drain starts after the 10th.
6. abort during LDI: next cycle all controls 0, code 3, IDLE. Async rstn pulse mid-RUN: start=0 immediately, busy=0.
